life_support_scheduler: RTL and testbench

LIFE_SUPPORT_SCHEDULER -- requirements
Module: life_support_scheduler

---
 rtl/life_support_scheduler.sv | 156 +++++++++++++++
 tb/tb_life_support_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/life_support_scheduler.sv
// ============================================================================
// life_support_scheduler : crew-request / emergency mode scheduler (rev 1.0)
// ============================================================================
`default_nettype none

module life_support_scheduler #(
  parameter int n          = 8,
  parameter int MIN_DWELL  = 4,
  parameter int PWR_LOW    = 10,
  parameter int PWR_RESUME = 50,
  parameter int O2_LOW     = 20,
  parameter int TEMP_LIMIT = 100,
  parameter int ALARM_CYC  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_def,
  input  logic         req_sth,
  input  logic         req_chrg,
  input  logic         atk,
  input  logic         fatal,
  input  logic [n-1:0] pwr,
  input  logic [n-1:0] temp,
  input  logic [n-1:0] o2,
  output logic [3:0]   mode,
  output logic         chrg,
  output logic         o2sup,
  output logic [1:0]   gnt,
  output logic [2:0]   state,
  output logic         alarm
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEFEND  = 3'd1,
    STEALTH = 3'd2,
    CHARGE  = 3'd3,
    EMERG   = 3'd4
  } state_t;

  localparam int             c_cnt_w      = $clog2(ALARM_CYC + 1);
  localparam logic [n-1:0]   c_pwr_low    = n'(PWR_LOW);
  localparam logic [n-1:0]   c_pwr_resume = n'(PWR_RESUME);
  localparam logic [n-1:0]   c_o2_low     = n'(O2_LOW);
  localparam logic [n-1:0]   c_temp_limit = n'(TEMP_LIMIT);
  localparam logic [n-1:0]   c_pwr_full   = {n{1'b1}};
  localparam logic [3:0]     c_dwell_load = 4'(MIN_DWELL - 1);
  localparam logic [c_cnt_w-1:0] c_alarm_cnt = c_cnt_w'(ALARM_CYC);

  state_t               r_state;
  logic                 r_chrg_low;  // current CHARGE was forced by low power
  logic                 r_rr_sth;    // round-robin pointer: 1 = STEALTH wins a tie
  logic [3:0]           r_dwell;
  logic [c_cnt_w-1:0]   r_emerg_cnt;

  state_t               w_next;
  state_t               w_arb;
  logic                 w_next_low;
  logic                 w_emerg;
  logic [c_cnt_w-1:0]   w_emerg_cnt_inc;

  assign w_emerg = fatal | (o2 < c_o2_low) | (temp >= c_temp_limit);
  assign w_emerg_cnt_inc = (r_emerg_cnt == c_alarm_cnt) ? r_emerg_cnt
                                                        : r_emerg_cnt + 1'b1;

  // Request arbitration; atk is known to be low wherever this result is used.
  always_comb begin
    w_arb = IDLE;
    if (req_def && req_sth)
      w_arb = r_rr_sth ? STEALTH : DEFEND;
    else if (req_def)
      w_arb = DEFEND;
    else if (req_sth)
      w_arb = STEALTH;
    else if (req_chrg && (pwr != c_pwr_full))
      w_arb = CHARGE;
  end

  always_comb begin
    w_next     = r_state;
    w_next_low = r_chrg_low;
    if (w_emerg) begin
      w_next     = EMERG;
      w_next_low = 1'b0;
    end else if (r_state == EMERG) begin
      w_next     = (pwr < c_pwr_resume) ? CHARGE : IDLE;
      w_next_low = (pwr < c_pwr_resume);
    end else if (pwr <= c_pwr_low) begin
      w_next     = CHARGE;
      w_next_low = 1'b1;
    end else if (atk) begin
      w_next     = DEFEND;
      w_next_low = 1'b0;
    end else if ((r_state == CHARGE) && r_chrg_low && (pwr < c_pwr_resume)) begin
      w_next     = CHARGE;
    end else if (((r_state == DEFEND) || (r_state == STEALTH)) && (r_dwell != 4'd0)) begin
      w_next     = r_state;
    end else begin
      w_next     = w_arb;
      w_next_low = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_chrg_low  <= 1'b0;
      r_rr_sth    <= 1'b0;
      r_dwell     <= 4'd0;
      r_emerg_cnt <= '0;
      mode        <= 4'b0000;
      chrg        <= 1'b0;
      o2sup       <= 1'b0;
      gnt         <= 2'd0;
      alarm       <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_chrg_low <= w_next_low;

      if ((w_next == DEFEND) || (w_next == STEALTH)) begin
        if (w_next != r_state)
          r_dwell <= c_dwell_load;
        else if (r_dwell != 4'd0)
          r_dwell <= r_dwell - 4'd1;
      end else begin
        r_dwell <= 4'd0;
      end

      if (w_next == DEFEND)
        r_rr_sth <= 1'b1;
      else if (w_next == STEALTH)
        r_rr_sth <= 1'b0;

      if (w_next == EMERG) begin
        r_emerg_cnt <= w_emerg_cnt_inc;
        alarm       <= (w_emerg_cnt_inc == c_alarm_cnt);
      end else begin
        r_emerg_cnt <= '0;
        alarm       <= 1'b0;
      end

      case (w_next)
        DEFEND:  begin mode <= 4'b0100; chrg <= 1'b0; o2sup <= 1'b0; gnt <= 2'd1; end
        STEALTH: begin mode <= 4'b1000; chrg <= 1'b0; o2sup <= 1'b0; gnt <= 2'd2; end
        CHARGE:  begin mode <= 4'b0001; chrg <= 1'b1; o2sup <= 1'b0; gnt <= 2'd3; end
        EMERG:   begin mode <= 4'b0010; chrg <= 1'b1; o2sup <= 1'b1; gnt <= 2'd0; end
        default: begin mode <= 4'b0000; chrg <= 1'b0; o2sup <= 1'b0; gnt <= 2'd0; end
      endcase
    end
  end

  assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_life_support_scheduler.sv
// Directed self-checking bench for life_support_scheduler.
`default_nettype none

module tb_life_support_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_def = 1'b0, req_sth = 1'b0, req_chrg = 1'b0;
  logic       atk = 1'b0, fatal = 1'b0;
  logic [7:0] pwr = 8'd100, temp = 8'd50, o2 = 8'd200;
  logic [3:0] mode;
  logic       chrg, o2sup, alarm;
  logic [1:0] gnt;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  life_support_scheduler dut (
    .clk(clk), .rst(rst),
    .req_def(req_def), .req_sth(req_sth), .req_chrg(req_chrg),
    .atk(atk), .fatal(fatal),
    .pwr(pwr), .temp(temp), .o2(o2),
    .mode(mode), .chrg(chrg), .o2sup(o2sup),
    .gnt(gnt), .state(state), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for a given state code, from the mode/gnt/control table.
  task automatic expect_all(input string tag, input int st, input bit al);
    logic [3:0] m;
    case (st)
      1:       m = 4'b0100;
      2:       m = 4'b1000;
      3:       m = 4'b0001;
      4:       m = 4'b0010;
      default: m = 4'b0000;
    endcase
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".mode"},  32'(mode),  32'(m));
    chk({tag, ".gnt"},   32'(gnt),   (st >= 1 && st <= 3) ? 32'(st) : 32'd0);
    chk({tag, ".chrg"},  32'(chrg),  (st == 3 || st == 4) ? 32'd1 : 32'd0);
    chk({tag, ".o2sup"}, 32'(o2sup), (st == 4) ? 32'd1 : 32'd0);
    chk({tag, ".alarm"}, 32'(alarm), 32'(al));
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b0;
    #1 expect_all("reset_async", 0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    expect_all("idle_after_reset", 0, 1'b0);

    // Round-robin DEFEND/STEALTH with 4-cycle dwell.
    req_def = 1'b1; req_sth = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      expect_all($sformatf("rr_%0d", i), ((i / 4) % 2 == 0) ? 1 : 2, 1'b0);
    end

    // Enter STEALTH (dwell 3), then atk forces DEFEND and reloads dwell.
    tick();
    expect_all("sth_entry", 2, 1'b0);
    atk = 1'b1;
    tick();
    expect_all("atk_preempt", 1, 1'b0);
    atk = 1'b0; req_def = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_all($sformatf("def_reload_%0d", i), 1, 1'b0);
    end
    tick();
    expect_all("def_to_sth", 2, 1'b0);

    // No requests: stay through dwell, then IDLE.
    req_sth = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_all($sformatf("sth_dwell_%0d", i), 2, 1'b0);
    end
    tick();
    expect_all("idle_no_req", 0, 1'b0);

    // atk blocks STEALTH.
    req_sth = 1'b1; atk = 1'b1;
    tick();
    expect_all("atk_no_sth", 1, 1'b0);
    atk = 1'b0; req_sth = 1'b0;

    // Low power during DEFEND dwell forces CHARGE; req_def ignored until resume.
    req_def = 1'b1; pwr = 8'd10;
    tick();
    expect_all("low_pwr_chg", 3, 1'b0);
    pwr = 8'd30;
    tick();
    expect_all("chg_hold_30", 3, 1'b0);
    pwr = 8'd49;
    tick();
    expect_all("chg_hold_49", 3, 1'b0);
    pwr = 8'd50;
    tick();
    expect_all("chg_resume_def", 1, 1'b0);
    req_def = 1'b0;

    // Low oxygen for 10 cycles: EMERG, alarm from the 8th cycle.
    o2 = 8'd19;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_all($sformatf("o2_emerg_%0d", i), 4, i >= 7);
    end
    o2 = 8'd200; pwr = 8'd30;
    tick();
    expect_all("emerg_to_chg", 3, 1'b0);
    pwr = 8'd100;
    tick();
    expect_all("chg_to_idle", 0, 1'b0);

    // Thresholds just outside emergency / low-power.
    pwr = 8'd11; o2 = 8'd20; temp = 8'd99;
    tick();
    expect_all("edge_no_emerg", 0, 1'b0);
    pwr = 8'd100;

    // Over-temperature wins over atk.
    temp = 8'd100; atk = 1'b1;
    tick();
    expect_all("temp_over_atk", 4, 1'b0);
    temp = 8'd50; atk = 1'b0;
    tick();
    expect_all("emerg_to_idle", 0, 1'b0);

    // Charge by request: leaves at full power or when request drops; ranks below req_def.
    req_chrg = 1'b1;
    tick();
    expect_all("req_chg", 3, 1'b0);
    pwr = 8'd255;
    tick();
    expect_all("chg_full_exit", 0, 1'b0);
    pwr = 8'd200;
    tick();
    expect_all("req_chg2", 3, 1'b0);
    req_def = 1'b1;
    tick();
    expect_all("def_over_chg", 1, 1'b0);
    req_def = 1'b0; req_chrg = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    expect_all("back_idle", 0, 1'b0);

    // Reset mid-EMERG with alarm set clears outputs without a clock.
    fatal = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    expect_all("fatal_alarm", 4, 1'b1);
    #2 rst = 1'b0;
    #1 expect_all("reset_mid_emerg", 0, 1'b0);
    fatal = 1'b0;
    tick();
    expect_all("reset_held", 0, 1'b0);
    rst = 1'b1;
    tick();
    expect_all("post_reset_idle", 0, 1'b0);

    // Emergency count restarts from zero after reset.
    fatal = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    expect_all("cnt_cleared_7", 4, 1'b0);
    tick();
    expect_all("cnt_cleared_8", 4, 1'b1);
    fatal = 1'b0;
    tick();
    expect_all("alarm_clear", 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
